aes_key_expand: RTL
===================

// Module: aes_key_expand
// PURPOSE
// - Iterative AES-128 key schedule; produces round keys 0..10, one per clock, from a 128-bit cipher key.
// - Sits directly upstream of the round stages, including the final round (SubBytes/ShiftRows/AddRoundKey).
// - Feeds each stage's 128-bit ip_key input.
// - Word packing matches the round data path: key[127:96]=w0 (column 0) ... key[31:0]=w3.
// PARAMETERS
// - NUM_ROUNDS   10   last round index; fixed at 10 for AES-128, other values unsupported
// - KEY_WIDTH    128  cipher/round key width; fixed
// PORTS
// - clk        in   1    single clock, rising edge
// - rst_n      in   1    asynchronous active-low reset
// - start      in   1    request expansion of ip_key; sampled only in IDLE
// - ip_key     in   128  cipher key, captured on accepted start
// - busy       out  1    high from accepted start until done
// - rk_valid   out  1    round_key/round_idx valid this cycle
// - round_idx  out  4    index 0..10 of the presented round key
// - round_key  out  128  current round key
// - done       out  1    one-cycle pulse with the round-10 key
// - rd_idx     in   4    stored-key read index (KEY_STORE_EN)
// - rd_key     out  128  stored round key[rd_idx] (KEY_STORE_EN)
// BEHAVIOUR
// - Reset (async assert, sync release): state=IDLE; all outputs 0; rcon=8'h01; key store cleared.
// - FSM IDLE -> EXPAND on start; EXPAND -> IDLE after round 10 is presented.
// - Accept: start=1 in IDLE. Edge N: ip_key is loaded into the key register; round_key=ip_key;
//   round_idx=0; rk_valid=1; busy=1.
// - Each following edge in EXPAND: round_idx+1, and the key is updated.
//   - temp = SubWord(RotWord(w3)) ^ {rcon,24'h0}
//   - w0'=w0^temp, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'
//   - rcon <= xtime(rcon); sequence 01,02,04,08,10,20,40,80,1b,36.
// - Latency: key k is presented on edge N+k; 11 consecutive rk_valid cycles with no gaps.
// - done=1 in the same cycle as round_idx=10. The next edge: IDLE, rk_valid=0, busy=0, done=0.
//   - round_key and round_idx hold their last values.
// - start while busy: ignored; ip_key is not recaptured. ip_key may change freely after acceptance.
// - start held high: a new expansion is accepted on the first IDLE cycle (edge N+11).
//   - Back-to-back throughput is one key set per 12 cycles.
// - Reset mid-expansion: immediate return to IDLE with outputs 0. No partial done.
// - SubWord: 4 independent S-box lookups (FIPS-197 table, combinational), all on the rotated w3.
// - rcon is 8-bit; the xtime wrap (0x80 -> 0x1b) is exact. rcon resets to 01 on every accept.
// CONFIGURATION
// - `define KEY_STORE_EN: 11x128 register file.
//   - Entry round_idx is written on every rk_valid cycle.
//   - rd_key = store[rd_idx], combinational.
//   - rd_idx > 10 returns 0.
//   - Contents persist until overwritten by a new expansion or reset.
//   - Lets the decryption direction replay keys in reverse.
// - Without KEY_STORE_EN: no storage is inferred; rd_key is tied to 0 and rd_idx is ignored.
// TESTING
// - FIPS-197 key 2b7e1516_28aed2a6_abf71588_09cf4f3c, start 1 cycle:
//   - idx0 = the key itself.
//   - idx1 = a0fafe17_88542cb1_23a33939_2a6c7605.
//   - idx10 = d014f9a8_c9ee2589_e13f0cc8_b6630ca6, with done=1.
// - All-zero key:
//   - idx1 = 62636363_62636363_62636363_62636363.
//   - idx10 = b4ef5bcb_3e92e211_23e951cf_6f8f188e.
//   - Check busy is high for exactly 11 cycles.
// - Pulse start again at idx 4 with a different ip_key -> ignored.
//   - Sequence completes with the original key's values.
//   - A later start in IDLE uses the new key.
// - Assert rst_n=0 at idx 6 -> same cycle: rk_valid=busy=done=0, round_key=0.
//   - After release with no start: stays IDLE.
// - start held high continuously -> two full expansions.
//   - rk_valid low for exactly 1 cycle between idx10 and the next idx0.
// - KEY_STORE_EN, after the FIPS key:
//   - rd_idx=10 -> d014f9a8...b6630ca6.
//   - rd_idx=0 -> 2b7e1516...09cf4f3c.
//   - rd_idx=15 -> 0.
// - Built without the macro: rd_key stays 0 for every rd_idx.

Source files
------------

// File: rtl/aes_key_expand.sv
// aes_key_expand: iterative AES-128 key schedule producing round keys 0..10,
// one per clock, from a 128-bit cipher key.
//   clk, rst_n    : clock (rising edge), asynchronous active-low reset
//   start, ip_key : request an expansion of ip_key (sampled only when idle)
//   busy          : high from the accepted start until done
//   rk_valid      : round_idx/round_key valid this cycle
//   round_idx     : index 0..10 of the presented round key
//   round_key     : current round key, key[127:96] = w0 ... key[31:0] = w3
//   done          : one-cycle pulse alongside round key 10
//   rd_idx/rd_key : stored round-key readback, present only with the
//                   KEY_STORE_EN macro defined; otherwise rd_key reads 0
module aes_key_expand #(
  parameter int unsigned NUM_ROUNDS = 10,
  parameter int unsigned KEY_WIDTH  = 128
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [KEY_WIDTH-1:0] ip_key,
  output logic                 busy,
  output logic                 rk_valid,
  output logic [3:0]           round_idx,
  output logic [KEY_WIDTH-1:0] round_key,
  output logic                 done,
  input  logic [3:0]           rd_idx,
  output logic [KEY_WIDTH-1:0] rd_key
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned RCON_W = 8;

  // FIPS-197 S-box, entry 0 in the most significant byte
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic {
    IDLE   = 1'b0,
    EXPAND = 1'b1
  } state_t;

  state_t                 state;
  logic [RCON_W-1:0]      rcon;
  logic [KEY_WIDTH-1:0]   next_key;
  logic [WORD_W-1:0]      w0, w1, w2, w3, rot, temp, n0, n1, n2, n3;

  // Byte i lives at bit offset (255-i)*8, i.e. {~i, 3'b000}
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [RCON_W-1:0] xtime(input logic [RCON_W-1:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  // One key-schedule step applied to the currently presented key
  always_comb begin
    w0       = round_key[127:96];
    w1       = round_key[95:64];
    w2       = round_key[63:32];
    w3       = round_key[31:0];
    rot      = {w3[23:0], w3[31:24]};
    temp     = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
               ^ {rcon, 24'h000000};
    n0       = w0 ^ temp;
    n1       = w1 ^ n0;
    n2       = w2 ^ n1;
    n3       = w3 ^ n2;
    next_key = {n0, n1, n2, n3};
  end

  // Control FSM with registered outputs; round_key doubles as the key register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      rk_valid  <= 1'b0;
      done      <= 1'b0;
      round_idx <= 4'd0;
      round_key <= '0;
      rcon      <= 8'h01;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state     <= EXPAND;
            busy      <= 1'b1;
            rk_valid  <= 1'b1;
            round_idx <= 4'd0;
            round_key <= ip_key;
            rcon      <= 8'h01;
          end
        end
        EXPAND: begin
          if (round_idx == 4'(NUM_ROUNDS)) begin
            // Last key has been presented; key and index hold
            state    <= IDLE;
            busy     <= 1'b0;
            rk_valid <= 1'b0;
            done     <= 1'b0;
          end else begin
            round_key <= next_key;
            round_idx <= round_idx + 4'd1;
            rcon      <= xtime(rcon);
            done      <= (round_idx == 4'(NUM_ROUNDS - 1));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef KEY_STORE_EN
  logic [KEY_WIDTH-1:0] store [0:NUM_ROUNDS];

  // Capture every presented round key so it can be replayed in any order
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= int'(NUM_ROUNDS); i++) store[i] <= '0;
    end else if (rk_valid) begin
      store[round_idx] <= round_key;
    end
  end

  always_comb begin
    rd_key = '0;
    if (rd_idx <= 4'(NUM_ROUNDS)) rd_key = store[rd_idx];
  end
`else
  logic unused_rd_idx;
  assign unused_rd_idx = ^rd_idx;
  assign rd_key        = '0;
`endif

endmodule
